// File: rtl/clock_pkg.sv
// Shared definitions for the clock front-end: key indices, 50 MHz cycle defaults,
// repeat-FSM state encoding and a counter-width helper.
package clock_pkg;

  localparam int unsigned NUM_KEYS      = 4;
  localparam int unsigned KEY_MIN_UNIT  = 0;
  localparam int unsigned KEY_MIN_TEN   = 1;
  localparam int unsigned KEY_HOUR_UNIT = 2;
  localparam int unsigned KEY_HOUR_TEN  = 3;

  localparam int unsigned DB_CYCLES_DEF     = 50_000;
  localparam int unsigned HOLD_CYCLES_DEF   = 25_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_HOLD   = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_e;

  // Width able to hold 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// Increment-command interface between the key conditioner (master) and the clock core (slave).
interface key_pulse_gen_if;
  import clock_pkg::*;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_pulse;

  modport master (input key_raw, output key_level, output key_pulse);
  modport slave  (output key_raw, input key_level, input key_pulse);

endinterface

// File: rtl/key_channel.sv
// One button: 2-flop synchroniser, debounce counter, level register and pulse generator.
// KEY_AUTOREPEAT_EN adds the HOLD/REPEAT auto-repeat FSM and its saturating timer.
module key_channel
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_pulse
);

  localparam int unsigned DB_W = cnt_width(DB_CYCLES);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            rise_c;

  // Debounce: count consecutive disagreeing cycles, toggle on the last one.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rise_c = level_d & ~level_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

  rep_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] timer_inc_c;
  logic             rep_pulse_c;

  assign timer_inc_c = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + TMR_W'(1);

  // A fresh press always restarts the hold phase; a released key drops back to idle silently.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rep_pulse_c = 1'b0;
    if (rise_c) begin
      state_d = REP_HOLD;
      timer_d = '0;
    end else begin
      case (state_q)
        REP_IDLE: begin
          timer_d = '0;
        end
        REP_HOLD: begin
          if (!sync2_q || !level_q) begin
            state_d = REP_IDLE;
            timer_d = '0;
          end else if (timer_q == TMR_W'(HOLD_CYCLES - 1)) begin
            state_d     = REP_REPEAT;
            timer_d     = '0;
            rep_pulse_c = 1'b1;
          end else begin
            timer_d = timer_inc_c;
          end
        end
        REP_REPEAT: begin
          if (!sync2_q || !level_q) begin
            state_d = REP_IDLE;
            timer_d = '0;
          end else if (timer_q == TMR_W'(REPEAT_CYCLES - 1)) begin
            timer_d     = '0;
            rep_pulse_c = 1'b1;
          end else begin
            timer_d = timer_inc_c;
          end
        end
        default: begin
          state_d = REP_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  assign pulse_d = rise_c | rep_pulse_c;
`else
  logic unused_cfg;

  assign unused_cfg = ^{32'(HOLD_CYCLES), 32'(REPEAT_CYCLES)};
  assign pulse_d    = rise_c;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      db_cnt_q <= '0;
`ifdef KEY_AUTOREPEAT_EN
      state_q  <= REP_IDLE;
      timer_q  <= '0;
`endif
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      db_cnt_q <= db_cnt_d;
`ifdef KEY_AUTOREPEAT_EN
      state_q  <= state_d;
      timer_q  <= timer_d;
`endif
    end
  end

  assign key_level = level_q;
  assign key_pulse = pulse_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Time-set button conditioner: four independent key channels feeding the increment interface.
// Auto-repeat is present only when KEY_AUTOREPEAT_EN is defined.
module key_pulse_gen
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  key_pulse_gen_if.master kif
);

  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] pulse_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (kif.key_raw[i]),
      .key_level(level_w[i]),
      .key_pulse(pulse_w[i])
    );
  end

  assign kif.key_level = level_w;
  assign kif.key_pulse = pulse_w;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Scoreboard bench for key_pulse_gen: directed scenarios plus random button traffic,
// checked cycle by cycle against a behavioural model (honours KEY_AUTOREPEAT_EN).
module tb_key_pulse_gen;
  import clock_pkg::*;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned REP  = 5;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] pls;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;
  int   edge_n;

  bit m_s1[4];
  bit m_s2[4];
  bit m_lvl[4];
  bit m_active[4];
  int m_run[4];
  int m_press[4];

  key_pulse_gen_if kif ();

  key_pulse_gen #(
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kif  (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: debounce as a run-length of disagreement, repeats as arithmetic on time since press.
  task automatic model_step(input logic [3:0] r, input logic rst,
                            output logic [3:0] lvl, output logic [3:0] pls);
    lvl = '0;
    pls = '0;
    for (int k = 0; k < 4; k++) begin
      bit s2, lv, nl, pl;
      int since;
      if (rst) begin
        m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_active[k] = 0;
        m_run[k] = 0; m_press[k] = 0;
        continue;
      end
      s2 = m_s2[k];
      lv = m_lvl[k];
      nl = lv;
      pl = 0;
      if (s2 != lv) begin
        m_run[k]++;
        if (m_run[k] == int'(DB)) begin
          nl = !lv;
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
      if (nl && !lv) begin
        pl = 1;
        m_active[k] = 1;
        m_press[k] = edge_n;
      end else if (m_active[k]) begin
        if (!s2 || !lv) begin
          m_active[k] = 0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else begin
          since = edge_n - m_press[k];
          if (since >= int'(HOLD) && ((since - int'(HOLD)) % int'(REP)) == 0) pl = 1;
        end
`endif
      end
      since = 0;
      m_lvl[k] = nl;
      m_s2[k]  = m_s1[k];
      m_s1[k]  = r[k];
      lvl[k] = nl;
      pls[k] = pl;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rst);
    exp_t e;
    @(negedge clk);
    kif.key_raw = r;
    reset = rst;
    model_step(r, rst, e.lvl, e.pls);
    e.cyc = edge_n;
    edge_n++;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0);
  endtask

  // Monitor: compare outputs just after every active edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (kif.key_level !== e.lvl) begin
          tests_failed++;
          $display("FAIL key_level edge=%0d got=%b exp=%b", e.cyc, kif.key_level, e.lvl);
        end
        tests_run++;
        if (kif.key_pulse !== e.pls) begin
          tests_failed++;
          $display("FAIL key_pulse edge=%0d got=%b exp=%b", e.cyc, kif.key_pulse, e.pls);
        end
      end
    end
  end

  initial begin
    int         run_left[4];
    logic [3:0] cur;
    tests_run    = 0;
    tests_failed = 0;
    edge_n       = 0;
    reset        = 1'b1;
    kif.key_raw  = '0;

    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

    // Clean press then release on the minute-unit key.
    hold(4'b0001, 10);
    hold(4'b0000, 30);

    // Bouncing minute-ten key settling high.
    for (int i = 0; i < 12; i++) step(((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
    hold(4'b0010, 20);
    hold(4'b0000, 30);

    // Glitch shorter than the debounce window.
    hold(4'b0100, 3);
    hold(4'b0000, 20);

    // Long hold on the hour-ten key.
    hold(4'b1000, 38);
    hold(4'b0000, 30);

    // Simultaneous press, then reset while both keys are held.
    hold(4'b1001, 12);
    step(4'b1001, 1'b1);
    hold(4'b1001, 15);
    hold(4'b0000, 30);

    // Random button traffic with occasional resets.
    cur = '0;
    for (int k = 0; k < 4; k++) run_left[k] = $urandom_range(1, 20);
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (run_left[k] == 0) begin
          cur[k] = ~cur[k];
          run_left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
        end
        run_left[k]--;
      end
      step(cur, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end
    hold(4'b0000, 20);

    repeat (4) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
